// File: rtl/vec_split_pipe.sv
// vec_split_pipe: buffered vector splitter.
// Words enter over a valid/ready handshake and wait in a DEPTH-entry FIFO.
// The head word is shown whole, along with its MSB, LSB and parity, and a
// toggle mask against the word delivered before it. A saturating counter
// records how many delivered words differed from their predecessor.
module vec_split_pipe #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] vec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] outv,
   output logic             o_msb,
   output logic             o_lsb,
   output logic             o_par,
   output logic [WIDTH-1:0] o_tog,
   output logic [CNT_W-1:0] chg_cnt
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ;
   logic [WIDTH-1:0] last_popped;

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] tog_raw;

   // Handshake flags depend only on occupancy, so there is no ready-to-ready path.
   always_comb begin
      in_ready  = (occ != OCC_FULL);
      out_valid = (occ != '0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
   end

   // Head-word views; everything reads as zero while the FIFO is empty.
   always_comb begin
      head    = mem[rd_ptr];
      tog_raw = head ^ last_popped;
      outv    = '0;
      o_tog   = '0;
      if (out_valid) begin
         outv  = head;
         o_tog = tog_raw;
      end
      o_msb = outv[WIDTH-1];
      o_lsb = outv[0];
      o_par = ^outv;
   end

   // Storage array; unoccupied entries are never observed, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= vec;
      end
   end

   // Write pointer with explicit wrap at DEPTH-1.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
      end else if (push) begin
         if (wr_ptr == PTR_LAST) begin
            wr_ptr <= '0;
         end else begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
      end
   end

   // Read pointer with explicit wrap at DEPTH-1.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         rd_ptr <= '0;
      end else if (pop) begin
         if (rd_ptr == PTR_LAST) begin
            rd_ptr <= '0;
         end else begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Occupancy: a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         occ <= '0;
      end else begin
         case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Remember the delivered word and count it if it differed from the previous one.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         last_popped <= '0;
         chg_cnt     <= '0;
      end else if (pop) begin
         last_popped <= head;
         if ((tog_raw != '0) && (chg_cnt != CNT_MAX)) begin
            chg_cnt <= chg_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vec_split_pipe.sv
// Self-checking bench for vec_split_pipe (WIDTH=3, DEPTH=2, CNT_W=3).
// A queue-based model predicts every output; directed phases pin the model
// with hand-computed values, then a random phase exercises the rest.
module tb_vec_split_pipe;

   localparam int unsigned WIDTH = 3;
   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 3;

   logic             clk;
   logic             areset;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] vec;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] outv;
   logic             o_msb;
   logic             o_lsb;
   logic             o_par;
   logic [WIDTH-1:0] o_tog;
   logic [CNT_W-1:0] chg_cnt;

   vec_split_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .areset(areset),
      .in_valid(in_valid), .in_ready(in_ready), .vec(vec),
      .out_valid(out_valid), .out_ready(out_ready), .outv(outv),
      .o_msb(o_msb), .o_lsb(o_lsb), .o_par(o_par), .o_tog(o_tog),
      .chg_cnt(chg_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Behavioural model
   int m_q[$];
   int m_last;
   int m_cnt;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_last = 0;
      m_cnt  = 0;
   endtask

   // Apply one clock edge to the model using the inputs present at that edge.
   task automatic model_edge();
      bit do_push;
      bit do_pop;
      int h;
      do_push = in_valid && (m_q.size() < DEPTH);
      do_pop  = (m_q.size() > 0) && out_ready;
      if (do_pop) begin
         h = m_q.pop_front();
         if (((h ^ m_last) != 0) && (m_cnt < CNT_SAT)) m_cnt++;
         m_last = h;
      end
      if (do_push) m_q.push_back(int'(vec));
   endtask

   // Compare every DUT output against the model's view of the current state.
   task automatic check_model();
      int h;
      bit v;
      v = (m_q.size() != 0);
      h = v ? m_q[0] : 0;
      chk("in_ready",  int'(in_ready),  int'(m_q.size() != DEPTH));
      chk("out_valid", int'(out_valid), int'(v));
      chk("outv",      int'(outv),      h);
      chk("o_msb",     int'(o_msb),     (h >> (WIDTH - 1)) & 1);
      chk("o_lsb",     int'(o_lsb),     h & 1);
      chk("o_par",     int'(o_par),     $countones(h) % 2);
      chk("o_tog",     int'(o_tog),     v ? (h ^ m_last) : 0);
      chk("chg_cnt",   int'(chg_cnt),   m_cnt);
   endtask

   // One cycle: check at the falling edge, advance the model at the rising
   // edge, then return 1 time unit later so the caller can drive new inputs.
   task automatic tick();
      @(negedge clk);
      check_model();
      @(posedge clk);
      if (areset) model_clear();
      else        model_edge();
      #1;
   endtask

   task automatic sync_reset_pulse();
      areset = 1'b1;
      model_clear();
      tick();
      tick();
      areset = 1'b0;
   endtask

   initial begin
      areset    = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      vec       = '0;
      model_clear();

      // Reset then idle
      #1;
      tick();
      tick();
      areset = 1'b0;
      tick();
      chk("rst_in_ready",  int'(in_ready),  1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_outv",      int'(outv),      0);
      chk("rst_o_tog",     int'(o_tog),     0);
      chk("rst_chg_cnt",   int'(chg_cnt),   0);

      // Single word, no back-pressure
      in_valid = 1'b1; vec = 3'b101; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("single_valid", int'(out_valid), 1);
      chk("single_outv",  int'(outv),      5);
      chk("single_msb",   int'(o_msb),     1);
      chk("single_lsb",   int'(o_lsb),     1);
      chk("single_par",   int'(o_par),     0);
      chk("single_tog",   int'(o_tog),     5);
      tick();
      chk("single_cnt",   int'(chg_cnt),   1);
      chk("single_empty", int'(out_valid), 0);

      // Fill and stall
      out_ready = 1'b0;
      in_valid = 1'b1; vec = 3'b011; tick();
      vec = 3'b110; tick();
      chk("full_in_ready", int'(in_ready), 0);
      vec = 3'b111; tick();
      chk("stall_head",  int'(outv),     3);
      chk("stall_ready", int'(in_ready), 0);
      out_ready = 1'b1; tick();
      chk("drain_head1",  int'(outv),     6);
      chk("drain_ready1", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("drain_head2", int'(outv), 7);
      tick();
      chk("drain_empty", int'(out_valid), 0);
      chk("drain_cnt",   int'(chg_cnt),   4);

      // Simultaneous push/pop at occupancy 1
      out_ready = 1'b0;
      in_valid = 1'b1; vec = 3'b010; tick();
      out_ready = 1'b1; tick();
      in_valid = 1'b0;
      chk("simul_valid", int'(out_valid), 1);
      chk("simul_outv",  int'(outv),      2);
      chk("simul_tog",   int'(o_tog),     0);
      chk("simul_cnt",   int'(chg_cnt),   5);
      tick();
      chk("simul_cnt2",  int'(chg_cnt),   5);
      chk("simul_empty", int'(out_valid), 0);

      // Counter sweep to saturation
      sync_reset_pulse();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 16; i++) begin
         vec = WIDTH'(i % 8);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("sweep_cnt", int'(chg_cnt), 7);

      // Reset asserted mid-operation with the FIFO full
      out_ready = 1'b0;
      in_valid = 1'b1; vec = 3'b001; tick();
      vec = 3'b100; tick();
      in_valid = 1'b0;
      chk("pre_rst_full", int'(in_ready), 0);
      #3;
      areset = 1'b1;
      model_clear();
      #1;
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_ready", int'(in_ready),  1);
      chk("midrst_cnt",   int'(chg_cnt),   0);
      chk("midrst_outv",  int'(outv),      0);
      tick();
      areset = 1'b0;
      in_valid = 1'b1; vec = 3'b100; tick();
      in_valid = 1'b0;
      chk("postrst_tog", int'(o_tog), 4);
      chk("postrst_cnt", int'(chg_cnt), 0);

      // Random traffic with occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         vec       = WIDTH'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            areset = 1'b1;
            model_clear();
         end else begin
            areset = 1'b0;
         end
         tick();
      end
      areset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vec_split_pipe.md
Name: vec_split_pipe

Overview:
- Parametrised, buffered successor of the combinational 3-bit vector splitter.
- Accepts WIDTH-bit words over a valid/ready handshake and holds them in a DEPTH-entry FIFO.
- Presents the head word whole (outv) plus derived fields: MSB, LSB, parity, and toggle mask against the previously delivered word.
- Keeps a saturating count of delivered words that changed. Sits between a stimulus/producer and any consumer that needs per-bit views with back-pressure.

Parameters:
- WIDTH, 3, vector width; must be ≥ 1.
- DEPTH, 2, FIFO entries; must be ≥ 1; power of two not required.
- CNT_W, 8, width of the change counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- areset  in  1  asynchronous reset, active-high.
- in_valid  in  1  producer has a word on vec.
- in_ready  out  1  FIFO can accept a word this cycle.
- vec  in  WIDTH  input word.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes the head word this cycle.
- outv  out  WIDTH  head word.
- o_msb  out  1  outv[WIDTH-1].
- o_lsb  out  1  outv[0].
- o_par  out  1  XOR of all outv bits.
- o_tog  out  WIDTH  outv XOR last_popped.
- chg_cnt  out  CNT_W  saturating count of popped words with nonzero o_tog.

Behaviour:
- Reset (async assert, sync release):
  - FIFO emptied: read/write pointers 0, occupancy 0.
  - last_popped = 0; chg_cnt = 0.
  - in_ready = 1 (DEPTH ≥ 1); out_valid = 0.
  - outv, o_msb, o_lsb, o_par = 0 while empty (outputs forced to 0 when out_valid = 0).
  - o_tog = 0 while empty.
- Push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (occupancy != DEPTH). It depends on state only, never on out_ready. A full FIFO does not accept a word in the same cycle as a pop; the word is accepted the next cycle.
- out_valid = (occupancy != 0).
- Latency: a word pushed at edge N is visible on outv with out_valid = 1 after edge N. There is no combinational vec-to-outv path.
- Pointers:
  - Wrap from DEPTH-1 to 0 explicitly.
  - Occupancy is +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop when occupancy = 1: head advances to the pushed word, occupancy stays 1, out_valid stays 1.
- Ordering is strict FIFO; no word is dropped or duplicated.
- Derived outputs are combinational from the head entry and last_popped, valid only while out_valid = 1.
- On pop:
  - last_popped <= outv.
  - If o_tog != 0 and chg_cnt != 2^CNT_W-1, chg_cnt increments.
  - At all-ones, chg_cnt holds (saturates, no wrap).
- in_valid with in_ready = 0: no state change. The producer must hold vec and in_valid until accepted; the block does not check this.
- out_ready with out_valid = 0: ignored.
- Reset asserted mid-stream: queued words are discarded immediately, outputs go to reset values in the same cycle, and no partial pop or count occurs.
- Contents of unoccupied FIFO entries are not observable.

Test Plan:
- Reset then idle (WIDTH=3, DEPTH=2): after areset pulse → in_ready=1, out_valid=0, outv=0, o_tog=0, chg_cnt=0.
- Single word, no back-pressure: push vec=3'b101 at edge N, out_ready=1 → out_valid=1 after N; outv=5, o_msb=1, o_lsb=1, o_par=0, o_tog=5; after pop chg_cnt=1, out_valid=0.
- Fill and stall: out_ready=0, push 3'b011 then 3'b110 → in_ready=0 after second push. A third push of 3'b111 held with in_valid=1 is not accepted. Raise out_ready → outputs 3, 6, 7 in order. The 7 is accepted the cycle after the first pop, not the same cycle.
- Simultaneous push/pop at occupancy 1: head=3'b010, push 3'b010 with out_ready=1 → occupancy stays 1. Next head is 2 with o_tog=0; popping it leaves chg_cnt unchanged.
- Counter sweep: stream vec=0..7 repeatedly with CNT_W=3, out_ready=1 → chg_cnt increments on every pop except the first (0 vs reset 0) and saturates at 7.
- Reset mid-operation: FIFO full (3'b001, 3'b100), assert areset asynchronously between edges → out_valid=0, in_ready=1, chg_cnt=0 immediately. After release, push 3'b100 → o_tog=4.
